// File: rtl/apb_master_if.sv
// apb_master_if: command/response handshake plus APB bus signals for apb_master.
// The master modport is the apb_master view; the slave modport is the view
// of whatever sits on the other side (command source and APB target).
interface apb_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  // command / response side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // APB side
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: turns single command requests into APB SETUP/ACCESS transfers
// and returns a one-cycle completion pulse with read data and error status.
// Optional macro APB_MASTER_TIMEOUT_EN: when defined, a transfer stalled in
// ACCESS for TIMEOUT_CYCLES cycles is abandoned and reported as an error.
// All outputs are registered; the async reset forces them immediately.
module apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          pclk,
  input logic          preset,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_reg;
  logic                  cmd_ready_reg;
  logic                  psel_reg;
  logic                  penable_reg;
  logic                  pwrite_reg;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;

  // A timeout of zero cycles is meaningless; the empty block keeps the
  // parameter referenced in builds without the timeout logic.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_guard
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_reg;

  // Count consecutive stalled ACCESS cycles; cleared when a transfer starts.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ACCESS && !bus.pready) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`endif

  // Transfer FSM with all bus and response outputs registered.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b1;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            pwrite_reg    <= bus.cmd_write;
            paddr_reg     <= bus.cmd_addr;
            pwdata_reg    <= bus.cmd_wdata;
            psel_reg      <= 1'b1;
            cmd_ready_reg <= 1'b0;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            // Error responses never carry data, nor do writes.
            rsp_rdata_reg <= (!pwrite_reg && !bus.pslverr) ? bus.prdata : '0;
            rsp_err_reg   <= bus.pslverr;
            rsp_valid_reg <= 1'b1;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (wait_cnt_reg == CNT_LAST) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
`endif
        end
        default: begin
          psel_reg      <= 1'b0;
          penable_reg   <= 1'b0;
          cmd_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.psel      = psel_reg;
  assign bus.penable   = penable_reg;
  assign bus.pwrite    = pwrite_reg;
  assign bus.paddr     = paddr_reg;
  assign bus.pwdata    = pwdata_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_apb_master;

  logic pclk   = 1'b0;
  logic preset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  apb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  apb_master #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    bus.prdata    = 8'h00;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // reset state
    #1 preset = 1'b1;
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_psel",      bus.psel, 0);
    check("rst_penable",   bus.penable, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err",   bus.rsp_err, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_paddr",     bus.paddr, 0);
    check("rst_pwdata",    bus.pwdata, 0);
    check("rst_pwrite",    bus.pwrite, 0);
    step();
    preset = 1'b0;
    step();
    check("idle_cmd_ready", bus.cmd_ready, 1);

    // zero-wait write 0x33 to 0x01
    bus.pready = 1'b1;
    issue(1'b1, 8'h01, 8'h33);
    step();
    bus.cmd_valid = 1'b0;
    check("wr_c1_psel",      bus.psel, 1);
    check("wr_c1_penable",   bus.penable, 0);
    check("wr_c1_paddr",     bus.paddr, 8'h01);
    check("wr_c1_pwrite",    bus.pwrite, 1);
    check("wr_c1_pwdata",    bus.pwdata, 8'h33);
    check("wr_c1_cmd_ready", bus.cmd_ready, 0);
    step();
    check("wr_c2_psel",      bus.psel, 1);
    check("wr_c2_penable",   bus.penable, 1);
    check("wr_c2_pwdata",    bus.pwdata, 8'h33);
    check("wr_c2_rsp_valid", bus.rsp_valid, 0);
    step();
    check("wr_c3_rsp_valid", bus.rsp_valid, 1);
    check("wr_c3_rsp_err",   bus.rsp_err, 0);
    check("wr_c3_rsp_rdata", bus.rsp_rdata, 0);
    check("wr_c3_cmd_ready", bus.cmd_ready, 1);
    check("wr_c3_psel",      bus.psel, 0);
    check("wr_c3_penable",   bus.penable, 0);
    check("wr_c3_pwdata",    bus.pwdata, 8'h33);
    $display("txn write addr=01 data=33 err=%0d", bus.rsp_err);
    step();
    check("wr_c4_rsp_valid", bus.rsp_valid, 0);

    // read 0x02 with three wait cycles; pready/pslverr high in SETUP are ignored
    bus.pready = 1'b0;
    issue(1'b0, 8'h02, 8'h99);
    step();
    bus.cmd_valid = 1'b0;
    check("rd_setup_psel",    bus.psel, 1);
    check("rd_setup_penable", bus.penable, 0);
    check("rd_setup_paddr",   bus.paddr, 8'h02);
    check("rd_setup_pwrite",  bus.pwrite, 0);
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    step();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    check("rd_acc1_penable",   bus.penable, 1);
    check("rd_acc1_rsp_valid", bus.rsp_valid, 0);
    for (int i = 2; i <= 4; i++) begin
      step();
      check("rd_acc_psel",      bus.psel, 1);
      check("rd_acc_penable",   bus.penable, 1);
      check("rd_acc_paddr",     bus.paddr, 8'h02);
      check("rd_acc_rsp_valid", bus.rsp_valid, 0);
    end
    bus.pready = 1'b1;
    bus.prdata = 8'h02;
    step();
    check("rd_done_rsp_valid", bus.rsp_valid, 1);
    check("rd_done_rsp_rdata", bus.rsp_rdata, 8'h02);
    check("rd_done_rsp_err",   bus.rsp_err, 0);
    check("rd_done_psel",      bus.psel, 0);
    $display("txn read addr=02 rdata=%0h err=%0d", bus.rsp_rdata, bus.rsp_err);
    bus.pready = 1'b0;
    bus.prdata = 8'h44;
    step();
    check("rd_hold_rsp_valid", bus.rsp_valid, 0);
    check("rd_hold_rsp_rdata", bus.rsp_rdata, 8'h02);

    // read 0x00 with slave error: data suppressed
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 8'hA5;
    issue(1'b0, 8'h00, 8'h00);
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("err_acc_penable", bus.penable, 1);
    step();
    check("err_rsp_valid", bus.rsp_valid, 1);
    check("err_rsp_err",   bus.rsp_err, 1);
    check("err_rsp_rdata", bus.rsp_rdata, 0);
    $display("txn read addr=00 rdata=%0h err=%0d", bus.rsp_rdata, bus.rsp_err);
    bus.pslverr = 1'b0;
    step();
    check("err_hold_rsp_valid", bus.rsp_valid, 0);
    check("err_hold_rsp_err",   bus.rsp_err, 1);

    // back-to-back writes with cmd_valid held high
    bus.prdata = 8'h00;
    bus.pready = 1'b1;
    issue(1'b1, 8'h05, 8'h5A);
    step();
    check("b2b_c1_psel",  bus.psel, 1);
    check("b2b_c1_paddr", bus.paddr, 8'h05);
    bus.cmd_addr  = 8'h06;
    bus.cmd_wdata = 8'h6B;
    step();
    check("b2b_c2_paddr",  bus.paddr, 8'h05);
    check("b2b_c2_pwdata", bus.pwdata, 8'h5A);
    step();
    check("b2b_c3_rsp_valid", bus.rsp_valid, 1);
    check("b2b_c3_psel",      bus.psel, 0);
    check("b2b_c3_cmd_ready", bus.cmd_ready, 1);
    $display("txn write addr=05 data=5a err=%0d", bus.rsp_err);
    step();
    bus.cmd_valid = 1'b0;
    check("b2b_c4_psel",      bus.psel, 1);
    check("b2b_c4_penable",   bus.penable, 0);
    check("b2b_c4_paddr",     bus.paddr, 8'h06);
    check("b2b_c4_pwdata",    bus.pwdata, 8'h6B);
    check("b2b_c4_rsp_valid", bus.rsp_valid, 0);
    step();
    check("b2b_c5_penable", bus.penable, 1);
    step();
    check("b2b_c6_rsp_valid", bus.rsp_valid, 1);
    check("b2b_c6_rsp_err",   bus.rsp_err, 0);
    $display("txn write addr=06 data=6b err=%0d", bus.rsp_err);
    step();
    check("b2b_c7_psel",   bus.psel, 0);
    check("b2b_c7_paddr",  bus.paddr, 8'h06);
    check("b2b_c7_pwdata", bus.pwdata, 8'h6B);

    // reset in ACCESS aborts, then a fresh write completes
    bus.pready = 1'b0;
    issue(1'b1, 8'h10, 8'h11);
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("abort_acc_penable", bus.penable, 1);
    #1 preset = 1'b1;
    #1;
    check("abort_psel",      bus.psel, 0);
    check("abort_penable",   bus.penable, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_paddr",     bus.paddr, 0);
    step();
    check("abort_held_psel", bus.psel, 0);
    #1 preset = 1'b0;
    step();
    check("abort_post_rsp_valid", bus.rsp_valid, 0);
    check("abort_post_cmd_ready", bus.cmd_ready, 1);
    $display("txn write addr=10 data=11 aborted by reset");
    bus.pready = 1'b1;
    issue(1'b1, 8'h01, 8'h77);
    step();
    bus.cmd_valid = 1'b0;
    check("rec_c1_psel",   bus.psel, 1);
    check("rec_c1_pwdata", bus.pwdata, 8'h77);
    step();
    check("rec_c2_penable", bus.penable, 1);
    step();
    check("rec_c3_rsp_valid", bus.rsp_valid, 1);
    check("rec_c3_rsp_err",   bus.rsp_err, 0);
    $display("txn write addr=01 data=77 err=%0d", bus.rsp_err);
    step();

    // slave never ready
    bus.pready = 1'b0;
    bus.prdata = 8'h5C;
    issue(1'b0, 8'h03, 8'h00);
    step();
    bus.cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      step();
      check("to_wait_psel",      bus.psel, 1);
      check("to_wait_rsp_valid", bus.rsp_valid, 0);
    end
    step();
    check("to_psel",      bus.psel, 0);
    check("to_penable",   bus.penable, 0);
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_rsp_err",   bus.rsp_err, 1);
    check("to_rsp_rdata", bus.rsp_rdata, 0);
    check("to_cmd_ready", bus.cmd_ready, 1);
    $display("txn read addr=03 timed out err=%0d", bus.rsp_err);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      check("stall_psel",      bus.psel, 1);
      check("stall_rsp_valid", bus.rsp_valid, 0);
    end
    $display("txn read addr=03 still waiting after 100 cycles");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
